if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch stage feeding the IF/ID pipeline register. Owns the PC, runs a request/ready handshake with instruction memory, and presents the instruction, PC+4 and PC page to IF/ID. It also drives IF/ID's flush input so that a zero word (NOP) is inserted whenever no valid fetch is available or a redirect occurs. Stalls come from the hazard unit through `pc_write`, the same signal that drives IF/ID's write enable.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `pc_write`  in  1  hazard-unit stall control; 0 means stall, and the fetched instruction is not consumed.
- `redirect_valid`  in  1  a taken branch or jump has been resolved.
- `redirect_target`  in  32  new PC; bits [1:0] are ignored and treated as 00.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  fetch address; held stable while `imem_req`=1 until `imem_ready` is sampled high.
- `imem_ready`  in  1  memory completes the request this cycle; may be high in the same cycle as the request (zero-latency memory).
- `imem_rdata`  in  32  instruction word; valid only when `imem_ready`=1.
- `fetch_valid`  out  1  the instruction, PC+4 and page outputs carry a real fetch.
- `instruction_out`  out  32  fetched instruction; zero when `fetch_valid`=0.
- `pc_plus_4_out`  out  32  address of the fetched instruction plus 4; zero when `fetch_valid`=0.
- `pc_page_out`  out  4  `pc_plus_4_out[31:28]`; zero when `fetch_valid`=0.
- `if_id_flush`  out  1  connects to IF/ID flush; equals `~fetch_valid | redirect_valid`.

## Operation
- Registers:
  - `pc`: address being fetched.
  - `buf_instr`: holding buffer for a stalled instruction.
  - `drain_addr`: address of an abandoned request.
  - 2-bit state.
- States: S_IDLE (reset state), S_FETCH, S_HOLD, S_DRAIN.
- **S_IDLE**
  - `imem_req`=0, `fetch_valid`=0.
  - Goes to S_FETCH unconditionally on the next edge.
- **S_FETCH**
  - `imem_req`=1, `imem_addr`=`pc`.
  - When `imem_ready`=1, the `imem_rdata` bypass drives `instruction_out` and `fetch_valid`=1 in the same cycle.
- Consume means `fetch_valid` & `pc_write` & ~`redirect_valid` at a clock edge.
  - In S_FETCH: `pc` <= `pc`+4 and the state stays S_FETCH. With zero-latency memory this gives 1 instruction/cycle.
  - In S_HOLD: `pc` <= `pc`+4 and the state goes to S_FETCH.
- In S_FETCH, if `imem_ready`=1 and `pc_write`=0 with no redirect, `buf_instr` <= `imem_rdata` and the state goes to S_HOLD.
- **S_HOLD**
  - `imem_req`=0, `fetch_valid`=1, outputs come from `buf_instr`/`pc`.
  - Leaves on consume or redirect.
- Redirect has priority over stall and consume; `pc_write` is ignored when `redirect_valid`=1.
  - In all cases `pc` <= {`redirect_target[31:2]`,2'b00}.
  - In S_FETCH with `imem_ready`=1, or in S_HOLD: the fetched word is dropped and the state goes to S_FETCH.
  - In S_FETCH with `imem_ready`=0: `drain_addr` <= `pc` and the state goes to S_DRAIN.
  - In S_DRAIN: `pc` is updated and the state stays S_DRAIN.
- **S_DRAIN**
  - `imem_req`=1, `imem_addr`=`drain_addr`, `fetch_valid`=0.
  - On `imem_ready`=1 the response is discarded and the state goes to S_FETCH.
- Arithmetic:
  - PC+4 is mod 2^32, so 32'hFFFF_FFFC + 4 = 0.
  - `pc_plus_4_out` = `pc`+4.

## Timing
- Reset values:
  - state S_IDLE, `pc`=`RESET_PC`, `buf_instr`=0, `drain_addr`=0.
  - All outputs 0 except `if_id_flush`=1.
- First request is issued 1 cycle after `rst` deasserts.
- Fetch-to-output latency is 0 cycles; output is combinational from `imem_rdata` when `imem_ready` is high in S_FETCH.
- A stalled instruction stays valid in S_HOLD for any number of stall cycles with no re-request to memory.
- Reset asserted mid-transaction aborts immediately: any outstanding request is dropped and `imem_req` falls asynchronously.

## Configuration
- `IF_FETCH_TRACE_EN` defined: `$display` lines `"@%t: IF_FETCH::CONSUME|HOLD|REDIRECT|DRAIN"` are printed on each corresponding edge, including the PC value.
- `IF_FETCH_TRACE_EN` undefined: no display output; functional behaviour is identical.

## Test plan
- Reset then zero-latency memory (`imem_ready`=1 constant), `pc_write`=1:
  - `imem_addr` 0,4,8,… on consecutive cycles.
  - `pc_plus_4_out` 4,8,12,….
  - `if_id_flush`=0 from the first fetch.
- Memory ready 3 cycles after request:
  - `fetch_valid`=0 and `if_id_flush`=1 for 2 cycles, then the instruction is presented.
  - `imem_addr` is stable throughout.
- Stall with `pc_write`=0 for 4 cycles while `imem_rdata`=32'h2002_0005 is returned:
  - S_HOLD holds 32'h2002_0005 valid with `imem_req`=0.
  - On release, the next request is at `pc`+4.
- Redirect to 32'h4000_0012 while a request to 0x10 is outstanding:
  - 0x10 is drained with `fetch_valid`=0.
  - The next request goes to 32'h4000_0010.
  - `pc_page_out`=4'h4 on that fetch.
- Simultaneous redirect and `pc_write`=0 in S_HOLD: redirect wins, the held word is dropped and `if_id_flush`=1.
- `RESET_PC`=32'hFFFF_FFFC: `pc_plus_4_out`=0, `pc_page_out`=0, and the next `imem_addr`=0.

Source files
------------

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction-fetch stage: PC, imem handshake and IF/ID presentation
// Define IF_FETCH_TRACE_EN to print consume/hold/redirect/drain events with the PC.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_write,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        fetch_valid,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_plus_4_out,
    output logic [3:0]  pc_page_out,
    output logic        if_id_flush
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic [31:0] redirect_pc;
    logic [31:0] pc_inc;
    logic [1:0]  unused_target_lsbs;
    logic        consume;

    assign redirect_pc        = {redirect_target[31:2], 2'b00};
    assign unused_target_lsbs = redirect_target[1:0];
    assign pc_inc             = pc_q + 32'd4;
    assign consume            = fetch_valid & pc_write & ~redirect_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            buf_instr_q  <= 32'h0;
            drain_addr_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            buf_instr_q  <= buf_instr_d;
            drain_addr_q <= drain_addr_d;
        end
    end

    // Output decode; in S_FETCH the memory word is bypassed straight to IF/ID.
    always_comb begin
        imem_req        = 1'b0;
        imem_addr       = 32'h0;
        fetch_valid     = 1'b0;
        instruction_out = 32'h0;
        case (state_q)
            S_FETCH: begin
                imem_req    = 1'b1;
                imem_addr   = pc_q;
                fetch_valid = imem_ready;
                if (imem_ready) begin
                    instruction_out = imem_rdata;
                end
            end
            S_HOLD: begin
                fetch_valid     = 1'b1;
                instruction_out = buf_instr_q;
            end
            S_DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr_q;
            end
            default: ;
        endcase
    end

    assign pc_plus_4_out = fetch_valid ? pc_inc : 32'h0;
    assign pc_page_out   = pc_plus_4_out[31:28];
    assign if_id_flush   = ~fetch_valid | redirect_valid;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        buf_instr_d  = buf_instr_q;
        drain_addr_d = drain_addr_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (redirect_valid) begin
                    // An unanswered request must still be retired before refetching.
                    if (imem_ready) begin
                        state_d = S_FETCH;
                    end else begin
                        drain_addr_d = pc_q;
                        state_d      = S_DRAIN;
                    end
                end else if (imem_ready && pc_write) begin
                    pc_d = pc_inc;
                end else if (imem_ready) begin
                    buf_instr_d = imem_rdata;
                    state_d     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    state_d = S_FETCH;
                end else if (pc_write) begin
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (!redirect_valid && imem_ready) begin
                    state_d = S_FETCH;
                end else if (redirect_valid && imem_ready) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef IF_FETCH_TRACE_EN
    always @(posedge clk) begin
        if (!rst) begin
            if (consume)
                $display("@%t: IF_FETCH::CONSUME pc=%h", $time, pc_q);
            if (state_q == S_FETCH && imem_ready && !pc_write && !redirect_valid)
                $display("@%t: IF_FETCH::HOLD pc=%h", $time, pc_q);
            if (redirect_valid)
                $display("@%t: IF_FETCH::REDIRECT pc=%h target=%h", $time, pc_q, redirect_pc);
            if (state_q == S_DRAIN && imem_ready)
                $display("@%t: IF_FETCH::DRAIN addr=%h pc=%h", $time, drain_addr_q, pc_q);
        end
    end
`else
    // Tracing compiled out; consume is kept for the trace build only.
    logic unused_consume;
    assign unused_consume = consume;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_write;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    logic        imem_req,  w_imem_req;
    logic [31:0] imem_addr, w_imem_addr;
    logic        fetch_valid, w_fetch_valid;
    logic [31:0] instruction_out, w_instruction_out;
    logic [31:0] pc_plus_4_out, w_pc_plus_4_out;
    logic [3:0]  pc_page_out, w_pc_page_out;
    logic        if_id_flush, w_if_id_flush;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    if_fetch_unit u_dut (
        .clk(clk), .rst(rst), .pc_write(pc_write),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .fetch_valid(fetch_valid), .instruction_out(instruction_out),
        .pc_plus_4_out(pc_plus_4_out), .pc_page_out(pc_page_out),
        .if_id_flush(if_id_flush)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk(clk), .rst(rst), .pc_write(pc_write),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .fetch_valid(w_fetch_valid), .instruction_out(w_instruction_out),
        .pc_plus_4_out(w_pc_plus_4_out), .pc_page_out(w_pc_page_out),
        .if_id_flush(w_if_id_flush)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen mid-cycle.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #3;
    endtask

    initial begin
        rst             = 1'b1;
        pc_write        = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        imem_ready      = 1'b0;
        imem_rdata      = 32'h0;
        tick;
        tick;
        settle;
        check("rst_req",   {31'h0, imem_req},    32'h0);
        check("rst_addr",  imem_addr,            32'h0);
        check("rst_valid", {31'h0, fetch_valid}, 32'h0);
        check("rst_instr", instruction_out,      32'h0);
        check("rst_pc4",   pc_plus_4_out,        32'h0);
        check("rst_page",  {28'h0, pc_page_out}, 32'h0);
        check("rst_flush", {31'h0, if_id_flush}, 32'h1);
        check("wrap_rst_pc4", w_pc_plus_4_out,   32'h0);

        tick;
        rst = 1'b0;
        settle;
        check("idle_req", {31'h0, imem_req}, 32'h0);
        tick;

        // zero-latency memory streaming
        imem_ready = 1'b1;
        pc_write   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            imem_rdata = 32'h1000_0000 + i;
            settle;
            check("zl_req",   {31'h0, imem_req},    32'h1);
            check("zl_addr",  imem_addr,            32'(4 * i));
            check("zl_valid", {31'h0, fetch_valid}, 32'h1);
            check("zl_instr", instruction_out,      32'h1000_0000 + i);
            check("zl_pc4",   pc_plus_4_out,        32'(4 * i + 4));
            check("zl_flush", {31'h0, if_id_flush}, 32'h0);
            if (i == 0) begin
                check("wrap_addr0", w_imem_addr,          32'hFFFF_FFFC);
                check("wrap_pc4",   w_pc_plus_4_out,      32'h0);
                check("wrap_page",  {28'h0, w_pc_page_out}, 32'h0);
                check("wrap_valid", {31'h0, w_fetch_valid}, 32'h1);
            end
            if (i == 1) begin
                check("wrap_addr1", w_imem_addr,     32'h0);
                check("wrap_pc4_1", w_pc_plus_4_out, 32'h4);
            end
            tick;
        end

        // memory answers on the third request cycle
        imem_ready = 1'b0;
        for (int j = 0; j < 2; j++) begin
            settle;
            check("lat_addr",  imem_addr,            32'h10);
            check("lat_valid", {31'h0, fetch_valid}, 32'h0);
            check("lat_flush", {31'h0, if_id_flush}, 32'h1);
            tick;
        end
        imem_ready = 1'b1;
        imem_rdata = 32'h2000_0010;
        settle;
        check("lat_addr3", imem_addr,            32'h10);
        check("lat_vld3",  {31'h0, fetch_valid}, 32'h1);
        check("lat_instr", instruction_out,      32'h2000_0010);
        check("lat_pc4",   pc_plus_4_out,        32'h14);
        tick;

        // stall for 4 cycles on the word at 0x14
        pc_write   = 1'b0;
        imem_rdata = 32'h2002_0005;
        settle;
        check("st_bypass", instruction_out, 32'h2002_0005);
        tick;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        for (int k = 0; k < 3; k++) begin
            settle;
            check("hold_req",   {31'h0, imem_req},    32'h0);
            check("hold_valid", {31'h0, fetch_valid}, 32'h1);
            check("hold_instr", instruction_out,      32'h2002_0005);
            check("hold_pc4",   pc_plus_4_out,        32'h18);
            tick;
        end
        pc_write = 1'b1;
        settle;
        check("rel_instr", instruction_out,      32'h2002_0005);
        check("rel_flush", {31'h0, if_id_flush}, 32'h0);
        tick;
        settle;
        check("rel_req",  {31'h0, imem_req}, 32'h1);
        check("rel_addr", imem_addr,         32'h18);

        // redirect with a completing response: go to 0x10
        tick;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0010;
        imem_ready      = 1'b1;
        imem_rdata      = 32'h1111_1111;
        settle;
        check("rd0_flush", {31'h0, if_id_flush}, 32'h1);
        tick;
        redirect_valid = 1'b0;
        imem_ready     = 1'b0;
        settle;
        check("rd0_addr", imem_addr, 32'h10);

        // redirect while 0x10 is outstanding: drain it
        redirect_valid  = 1'b1;
        redirect_target = 32'h4000_0012;
        settle;
        check("rd1_flush", {31'h0, if_id_flush}, 32'h1);
        tick;
        redirect_valid = 1'b0;
        settle;
        check("dr_req",   {31'h0, imem_req},    32'h1);
        check("dr_addr",  imem_addr,            32'h10);
        check("dr_valid", {31'h0, fetch_valid}, 32'h0);
        tick;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        settle;
        check("dr_addr2", imem_addr,            32'h10);
        check("dr_vld2",  {31'h0, fetch_valid}, 32'h0);
        check("dr_instr", instruction_out,      32'h0);
        tick;
        imem_rdata = 32'h3000_0001;
        settle;
        check("tgt_addr",  imem_addr,            32'h4000_0010);
        check("tgt_valid", {31'h0, fetch_valid}, 32'h1);
        check("tgt_pc4",   pc_plus_4_out,        32'h4000_0014);
        check("tgt_page",  {28'h0, pc_page_out}, 32'h4);
        tick;

        // stall into HOLD, then redirect together with pc_write=0
        pc_write   = 1'b0;
        imem_rdata = 32'h0000_0055;
        tick;
        imem_ready = 1'b0;
        settle;
        check("h2_instr", instruction_out, 32'h55);
        check("h2_req",   {31'h0, imem_req}, 32'h0);
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0100;
        settle;
        check("h2_flush", {31'h0, if_id_flush}, 32'h1);
        tick;
        redirect_valid = 1'b0;
        pc_write       = 1'b1;
        settle;
        check("h2_addr",  imem_addr,            32'h100);
        check("h2_valid", {31'h0, fetch_valid}, 32'h0);
        check("h2_drop",  instruction_out,      32'h0);

        // asynchronous reset drops the outstanding request between edges
        check("ar_pre", {31'h0, imem_req}, 32'h1);
        rst = 1'b1;
        #1;
        check("ar_req",   {31'h0, imem_req}, 32'h0);
        check("ar_flush", {31'h0, if_id_flush}, 32'h1);
        tick;
        rst = 1'b0;
        tick;
        settle;
        check("ar_restart", imem_addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
